// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 64-bit divider.
// Holds the FSM encoding and the two's-complement helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam int DIV_ITERS = 64;

  localparam logic [63:0] INT_MIN_64 =
    64'h8000_0000_0000_0000;

  localparam logic [63:0] ALL_ONES_64 =
    64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] neg64(
    input logic [63:0] x
  );
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/div_64_seq_add.sv
// 64-bit ripple-carry adder shared with the execute datapath.
// Overflow is the carry into vs. out of the sign bit.
module ADD_64 (
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic [63:0] Sum,
  output logic        Cout,
  output logic        Overflow
);

  logic [64:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 64; i++) begin : g_fa
    assign Sum[i] = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) |
                    (c[i] & (A[i] ^ B[i]));
  end

  assign Cout     = c[64];
  assign Overflow = c[64] ^ c[63];

endmodule

// File: rtl/div_64_seq.sv
// Restoring 64-bit divider for DIV/DIVU/REM/REMU.
// One trial subtraction per cycle through ADD_64, fixed latency.
module div_64_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e state_q, state_d;

  logic [63:0] q_q;
  logic [63:0] d_q;
  logic [63:0] r_q;
  logic [63:0] dvd_q;
  logic [5:0]  cnt_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        dz_q;
  logic        ovf_q;

  logic [63:0] quot_q;
  logic [63:0] rem_q;
  logic        dbz_q;

  logic [63:0] r_sh;
  logic [63:0] diff;
  logic        cout;
  logic        ge;
  logic        unused_ovf;

  logic        a_neg;
  logic        b_neg;
  logic [63:0] q_fix;
  logic [63:0] r_fix;

  assign a_neg = is_signed & dividend[63];
  assign b_neg = is_signed & divisor[63];

  // q_q doubles as the dividend shift register
  assign r_sh = {r_q[62:0], q_q[63]};

  ADD_64 u_add (
    .A        (r_sh),
    .B        (~d_q),
    .Cin      (1'b1),
    .Sum      (diff),
    .Cout     (cout),
    .Overflow (unused_ovf)
  );

  // A bit shifted out of r_q means r_sh >= 2^64 > divisor
  assign ge = cout | r_q[63];

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == 6'(DIV_ITERS - 1))
          state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_fix = q_neg_q ? neg64(q_q) : q_q;
    r_fix = r_neg_q ? neg64(r_q) : r_q;
    unique case (1'b1)
      dz_q: begin
        q_fix = ALL_ONES_64;
        r_fix = dvd_q;
      end
      ovf_q: begin
        q_fix = INT_MIN_64;
        r_fix = 64'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            q_q     <= a_neg ? neg64(dividend)
                             : dividend;
            d_q     <= b_neg ? neg64(divisor)
                             : divisor;
            r_q     <= '0;
            cnt_q   <= '0;
            dvd_q   <= dividend;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dz_q    <= (divisor == 64'd0);
            ovf_q   <= is_signed &&
                       dividend == INT_MIN_64 &&
                       divisor == ALL_ONES_64;
          end
        end
        CALC: begin
          r_q   <= ge ? diff : r_sh;
          q_q   <= {q_q[62:0], ge};
          cnt_q <= cnt_q + 6'd1;
        end
        FIX: begin
          quot_q <= q_fix;
          rem_q  <= r_fix;
          dbz_q  <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_64_seq.sv
// Self-checking bench for div_64_seq.
// Directed corner cases plus random ops against a plain-arithmetic model.
module tb_div_64_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  div_64_seq #(.WIDTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic void ref_div(
    input  bit          sg,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] q,
    output logic [63:0] r
  );
    longint sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (!sg) begin
      q = a / b;
      r = a % b;
    end else if (a == 64'h8000_0000_0000_0000 &&
                 b == '1) begin
      q = a;
      r = 64'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic count_dones(
    input  int n,
    output int cnt
  );
    cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  // inj: edge index at which a stray start is presented
  // abort: edge index at which reset is asserted (0 = none)
  task automatic run_op(
    input bit          sg,
    input logic [63:0] a,
    input logic [63:0] b,
    input int          inj,
    input int          abort
  );
    logic [63:0] eq, er;
    int n, extra;
    ref_div(sg, a, b, eq, er);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_acc", 64'(busy), 64'd1);
    if (abort > 0) begin
      repeat (abort - 1) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_q", quotient, 64'd0);
      chk("rst_r", remainder, 64'd0);
      chk("rst_dz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_dones(70, extra);
      chk("abort_nodone", 64'(extra), 64'd0);
    end else begin
      n = 0;
      for (int i = 1; i <= 80; i++) begin
        if (i == inj) begin
          start     = 1'b1;
          is_signed = 1'b0;
          dividend  = 64'd9;
          divisor   = 64'd3;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done) begin
          n = i;
          break;
        end
      end
      if (n == 0) begin
        chk("done_timeout", 64'd0, 64'd1);
      end else begin
        chk("latency", 64'(n), 64'd65);
        chk("busy_done", 64'(busy), 64'd0);
        chk("quot", quotient, eq);
        chk("rem", remainder, er);
        chk("dz", 64'(div_by_zero),
            64'(b == 64'd0));
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("hold_q", quotient, eq);
        chk("hold_r", remainder, er);
      end
      if (inj > 0) begin
        count_dones(70, extra);
        chk("no_2nd_done", 64'(extra), 64'd0);
      end
    end
  endtask

  logic [63:0] ra, rb;
  int sel;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_q", quotient, 64'd0);
    chk("reset_r", remainder, 64'd0);
    chk("reset_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 64'd100, 64'd7, 0, 0);
    run_op(1'b1, -64'sd7, 64'd2, 0, 0);
    run_op(1'b0, -64'sd7, 64'd2, 0, 0);
    run_op(1'b1, 64'd5, 64'd0, 0, 0);
    run_op(1'b0, 64'd5, 64'd0, 0, 0);
    run_op(1'b1, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op(1'b0, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0001, 0, 0);
    run_op(1'b0, 64'd50, 64'd5, 10, 0);
    run_op(1'b0, 64'd9, 64'd3, 0, 0);
    run_op(1'b1, 64'd123456789, 64'd1000, 0, 30);
    run_op(1'b1, -64'sd1000, -64'sd33, 0, 0);

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 3));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      unique case (sel)
        0: ;
        1: rb = 64'($urandom_range(1, 1000));
        2: rb = {32'd0, $urandom};
        default: begin
          ra = {32'd0, $urandom};
          rb = 64'($urandom_range(0, 20));
        end
      endcase
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op(1'($urandom_range(0, 1)),
             ra, rb, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
